// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: M/W writeback first, then deferred multdiv
// results from a small FIFO, then a direct multdiv result; a per-register
// scoreboard flags pending multdiv destinations and stalls F/D on hazards.
module reg_write_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LINK_REG   = 31,
    parameter int unsigned PEND_DEPTH = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [31:0]                       fd_ir,
    input  logic [31:0]                       mw_ir,
    input  logic [DATA_W-1:0]                 mw_data,
    input  logic                              md_issue,
    input  logic [REG_AW-1:0]                 md_issue_dest,
    input  logic                              md_ready,
    input  logic [REG_AW-1:0]                 md_dest,
    input  logic [DATA_W-1:0]                 md_result,
    output logic [REG_AW-1:0]                 read_a,
    output logic [REG_AW-1:0]                 read_b,
    output logic [REG_AW-1:0]                 write_d,
    output logic [DATA_W-1:0]                 write_data,
    output logic                              we,
    output logic                              stall,
    output logic                              md_hold,
    output logic [$clog2(PEND_DEPTH+1)-1:0]   pend_count
);

    localparam int unsigned NUM_REGS = 2 ** REG_AW;
    localparam int unsigned CNT_W    = $clog2(PEND_DEPTH + 1);
    localparam int unsigned PTR_W    = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;

    // Opcodes that write a destination register (jal uses the link register).
    function automatic logic isWriteOp(input logic [4:0] op);
        return (op == 5'd0) || (op == 5'd3) || (op == 5'd5) || (op == 5'd8);
    endfunction

    function automatic logic [REG_AW-1:0] destOf(input logic [4:0] op, input logic [4:0] rd);
        return (op == 5'd3) ? REG_AW'(LINK_REG) : REG_AW'(rd);
    endfunction

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(PEND_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [4:0] fdOp, fdRd, fdRs, fdRt;
    logic [4:0] mwOp, mwRd;
    logic       unusedBits;

    assign fdOp = fd_ir[31:27];
    assign fdRd = fd_ir[26:22];
    assign fdRs = fd_ir[21:17];
    assign fdRt = fd_ir[16:12];
    assign mwOp = mw_ir[31:27];
    assign mwRd = mw_ir[26:22];
    // Instruction fields the arbiter never looks at.
    assign unusedBits = ^{fd_ir[11:0], mw_ir[21:0]};

    logic                mwWr;
    logic [REG_AW-1:0]   mwDest;
    logic                fdWr;
    logic [REG_AW-1:0]   fdDest;

    assign mwWr   = isWriteOp(mwOp);
    assign mwDest = destOf(mwOp, mwRd);
    assign fdWr   = isWriteOp(fdOp);
    assign fdDest = destOf(fdOp, fdRd);

    logic [NUM_REGS-1:0] scoreboard;
    logic [NUM_REGS-1:0] sbSet;
    logic [NUM_REGS-1:0] sbClr;

    logic [REG_AW-1:0]   destQ [PEND_DEPTH];
    logic [DATA_W-1:0]   dataQ [PEND_DEPTH];
    logic [PTR_W-1:0]    headPtr;
    logic [PTR_W-1:0]    tailPtr;
    logic                fifoEmpty;
    logic                fifoFull;
    logic                push;
    logic                pop;
    logic                direct;

    assign fifoEmpty = (pend_count == '0);
    assign fifoFull  = (pend_count == CNT_W'(PEND_DEPTH));

    // Register-file read port selection from the F/D instruction format.
    always_comb begin
        read_a = REG_AW'(fdRs);
        read_b = REG_AW'(fdRt);
        case (fdOp)
            5'd2, 5'd4, 5'd6: begin
                read_a = REG_AW'(fdRd);
                read_b = REG_AW'(fdRs);
            end
            5'd7, 5'd8: begin
                read_a = REG_AW'(fdRs);
                read_b = REG_AW'(fdRd);
            end
            default: ;
        endcase
    end

    // Write-port priority, FIFO push/pop and multdiv backpressure.
    always_comb begin
        we         = 1'b0;
        write_d    = '0;
        write_data = '0;
        pop        = 1'b0;
        push       = 1'b0;
        direct     = 1'b0;
        md_hold    = 1'b0;
        sbClr      = '0;
        if (!reset) begin
            if (mwWr) begin
                write_d    = mwDest;
                write_data = mw_data;
                we         = (mwDest != '0);
            end else if (!fifoEmpty) begin
                pop        = 1'b1;
                write_d    = destQ[headPtr];
                write_data = dataQ[headPtr];
                we         = (destQ[headPtr] != '0);
                sbClr[destQ[headPtr]] = we;
            end else if (md_ready) begin
                direct     = 1'b1;
                write_d    = md_dest;
                write_data = md_result;
                we         = (md_dest != '0);
                sbClr[md_dest] = we;
            end
            md_hold = fifoFull && !pop;
            // r0 results are consumed without queueing.
            push    = md_ready && !md_hold && !direct && (md_dest != '0);
        end
    end

    // Scoreboard set request from a newly issued mult/div.
    always_comb begin
        sbSet = '0;
        if (md_issue && (md_issue_dest != '0)) begin
            sbSet[md_issue_dest] = 1'b1;
        end
    end

    // F/D hazard against any pending multdiv destination.
    always_comb begin
        stall = !reset && (scoreboard[read_a] || scoreboard[read_b] ||
                           (fdWr && scoreboard[fdDest]));
    end

    // Scoreboard and FIFO control state; a same-cycle set beats a clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            scoreboard <= '0;
            headPtr    <= '0;
            tailPtr    <= '0;
            pend_count <= '0;
        end else begin
            scoreboard <= (scoreboard & ~sbClr) | sbSet;
            if (push) tailPtr <= nextPtr(tailPtr);
            if (pop)  headPtr <= nextPtr(headPtr);
            case ({push, pop})
                2'b10:   pend_count <= pend_count + CNT_W'(1);
                2'b01:   pend_count <= pend_count - CNT_W'(1);
                default: pend_count <= pend_count;
            endcase
        end
    end

    // FIFO payload storage.
    always_ff @(posedge clock) begin
        if (push) begin
            destQ[tailPtr] <= md_dest;
            dataQ[tailPtr] <= md_result;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with hand-computed expectations.
module tb_reg_write_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] fd_ir;
    logic [31:0] mw_ir;
    logic [31:0] mw_data;
    logic        md_issue;
    logic [4:0]  md_issue_dest;
    logic        md_ready;
    logic [4:0]  md_dest;
    logic [31:0] md_result;
    logic [4:0]  read_a;
    logic [4:0]  read_b;
    logic [4:0]  write_d;
    logic [31:0] write_data;
    logic        we;
    logic        stall;
    logic        md_hold;
    logic [1:0]  pend_count;

    int tests = 0;
    int fails = 0;

    reg_write_arbiter #(
        .DATA_W(32), .REG_AW(5), .LINK_REG(31), .PEND_DEPTH(2)
    ) dut (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .mw_ir(mw_ir), .mw_data(mw_data),
        .md_issue(md_issue), .md_issue_dest(md_issue_dest), .md_ready(md_ready),
        .md_dest(md_dest), .md_result(md_result), .read_a(read_a), .read_b(read_b),
        .write_d(write_d), .write_data(write_data), .we(we), .stall(stall),
        .md_hold(md_hold), .pend_count(pend_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ir(input int op, input int rd, input int rs, input int rt);
        return {5'(op), 5'(rd), 5'(rs), 5'(rt), 12'h000};
    endfunction

    // Apply one cycle of inputs at the falling edge and let combinational outputs settle.
    task automatic apply(input logic rst, input logic [31:0] fd, input logic [31:0] mw,
                         input logic [31:0] mwd, input logic iss, input int issD,
                         input logic rdy, input int mdD, input logic [31:0] mdR);
        @(negedge clock);
        reset         = rst;
        fd_ir         = fd;
        mw_ir         = mw;
        mw_data       = mwd;
        md_issue      = iss;
        md_issue_dest = 5'(issD);
        md_ready      = rdy;
        md_dest       = 5'(mdD);
        md_result     = mdR;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] idleMw;
    logic [31:0] aluMw;

    initial begin
        idleMw = ir(2, 0, 0, 0);
        aluMw  = ir(0, 4, 0, 0);
        reset = 1'b1; fd_ir = '0; mw_ir = idleMw; mw_data = '0;
        md_issue = 1'b0; md_issue_dest = '0; md_ready = 1'b0; md_dest = '0; md_result = '0;

        // Reset cycle with busy inputs: everything gated, issue/ready ignored
        apply(1, ir(0, 1, 3, 0), aluMw, 32'h55, 1, 3, 1, 5, 32'h5);
        chk("rst_we", 32'(we), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_hold", 32'(md_hold), 0);
        chk("rst_pend", 32'(pend_count), 0);
        apply(0, ir(0, 1, 3, 0), idleMw, 0, 0, 0, 0, 0, 0);
        chk("post_rst_stall", 32'(stall), 0);
        chk("post_rst_pend", 32'(pend_count), 0);
        chk("idle_we", 32'(we), 0);
        chk("rd_op0_a", 32'(read_a), 3);

        // Read-port decode and M/W writes (jal -> link register, r0 suppressed)
        apply(0, ir(2, 1, 2, 3), ir(3, 0, 0, 0), 32'h40, 0, 0, 0, 0, 0);
        chk("rd_op2_a", 32'(read_a), 1);
        chk("rd_op2_b", 32'(read_b), 2);
        chk("jal_we", 32'(we), 1);
        chk("jal_wd", 32'(write_d), 31);
        chk("jal_data", write_data, 32'h40);
        apply(0, ir(7, 1, 2, 3), ir(0, 0, 0, 0), 32'h66, 0, 0, 0, 0, 0);
        chk("rd_op7_a", 32'(read_a), 2);
        chk("rd_op7_b", 32'(read_b), 1);
        chk("r0_mw_we", 32'(we), 0);
        apply(0, ir(1, 1, 2, 3), aluMw, 32'h55, 0, 0, 0, 0, 0);
        chk("rd_op1_a", 32'(read_a), 2);
        chk("rd_op1_b", 32'(read_b), 3);
        chk("alu_wd", 32'(write_d), 4);
        chk("alu_data", write_data, 32'h55);

        // Source hazard on r7 until the cycle after its result is written
        apply(0, '0, idleMw, 0, 1, 7, 0, 0, 0);
        chk("issue7_stall", 32'(stall), 0);
        apply(0, ir(0, 1, 7, 2), idleMw, 0, 0, 0, 0, 0, 0);
        chk("haz7_stall_a", 32'(stall), 1);
        apply(0, ir(0, 1, 7, 2), idleMw, 0, 0, 0, 0, 0, 0);
        chk("haz7_stall_b", 32'(stall), 1);
        apply(0, ir(0, 1, 7, 2), idleMw, 0, 0, 0, 1, 7, 32'h77);
        chk("direct7_we", 32'(we), 1);
        chk("direct7_wd", 32'(write_d), 7);
        chk("direct7_data", write_data, 32'h77);
        chk("direct7_stall", 32'(stall), 1);
        apply(0, ir(0, 1, 7, 2), idleMw, 0, 0, 0, 0, 0, 0);
        chk("haz7_clear", 32'(stall), 0);

        // Destination hazard on r10
        apply(0, '0, idleMw, 0, 1, 10, 0, 0, 0);
        apply(0, ir(5, 10, 0, 0), idleMw, 0, 0, 0, 0, 0, 0);
        chk("haz10_stall", 32'(stall), 1);
        apply(0, ir(5, 10, 0, 0), idleMw, 0, 0, 0, 1, 10, 32'hAA);
        chk("direct10_wd", 32'(write_d), 10);
        apply(0, ir(5, 10, 0, 0), idleMw, 0, 0, 0, 0, 0, 0);
        chk("haz10_clear", 32'(stall), 0);

        // M/W write beats a ready result, which is deferred one entry
        apply(0, '0, aluMw, 32'h11, 0, 0, 1, 9, 32'h99);
        chk("pri_wd", 32'(write_d), 4);
        chk("pri_data", write_data, 32'h11);
        chk("pri_hold", 32'(md_hold), 0);
        apply(0, '0, idleMw, 0, 0, 0, 0, 0, 0);
        chk("defer_pend1", 32'(pend_count), 1);
        chk("defer_we", 32'(we), 1);
        chk("defer_wd", 32'(write_d), 9);
        chk("defer_data", write_data, 32'h99);
        apply(0, '0, idleMw, 0, 0, 0, 0, 0, 0);
        chk("defer_pend0", 32'(pend_count), 0);
        chk("defer_idle_we", 32'(we), 0);

        // Fill the FIFO under continuous M/W writes, hold the third, drain in order
        apply(0, '0, aluMw, 32'h44, 0, 0, 1, 11, 32'hA1);
        chk("fill1_hold", 32'(md_hold), 0);
        apply(0, '0, aluMw, 32'h44, 0, 0, 1, 12, 32'hA2);
        chk("fill2_pend", 32'(pend_count), 1);
        chk("fill2_hold", 32'(md_hold), 0);
        apply(0, '0, aluMw, 32'h44, 0, 0, 1, 13, 32'hA3);
        chk("fill3_pend", 32'(pend_count), 2);
        chk("fill3_hold", 32'(md_hold), 1);
        apply(0, '0, idleMw, 0, 0, 0, 1, 13, 32'hA3);
        chk("drain1_pend", 32'(pend_count), 2);
        chk("drain1_hold", 32'(md_hold), 0);
        chk("drain1_wd", 32'(write_d), 11);
        chk("drain1_data", write_data, 32'hA1);
        apply(0, '0, idleMw, 0, 0, 0, 0, 0, 0);
        chk("drain2_pend", 32'(pend_count), 2);
        chk("drain2_wd", 32'(write_d), 12);
        chk("drain2_data", write_data, 32'hA2);
        apply(0, '0, idleMw, 0, 0, 0, 0, 0, 0);
        chk("drain3_pend", 32'(pend_count), 1);
        chk("drain3_wd", 32'(write_d), 13);
        chk("drain3_data", write_data, 32'hA3);
        apply(0, '0, idleMw, 0, 0, 0, 0, 0, 0);
        chk("drain_empty", 32'(pend_count), 0);
        chk("drain_idle_we", 32'(we), 0);

        // r0 result discarded on an idle port
        apply(0, '0, idleMw, 0, 0, 0, 1, 0, 32'hDEAD);
        chk("r0_md_we", 32'(we), 0);
        chk("r0_md_hold", 32'(md_hold), 0);
        apply(0, '0, idleMw, 0, 0, 0, 0, 0, 0);
        chk("r0_md_pend", 32'(pend_count), 0);

        // Reset with a full FIFO and a pending scoreboard bit
        apply(0, '0, idleMw, 0, 1, 20, 0, 0, 0);
        apply(0, '0, aluMw, 32'h44, 0, 0, 1, 21, 32'hB1);
        apply(0, '0, aluMw, 32'h44, 0, 0, 1, 22, 32'hB2);
        chk("pre_rst_pend1", 32'(pend_count), 1);
        apply(0, ir(1, 0, 20, 0), aluMw, 32'h44, 0, 0, 0, 0, 0);
        chk("pre_rst_pend2", 32'(pend_count), 2);
        chk("pre_rst_stall", 32'(stall), 1);
        chk("pre_rst_hold", 32'(md_hold), 1);
        apply(1, ir(1, 0, 20, 0), idleMw, 0, 1, 5, 1, 23, 32'hB3);
        chk("in_rst_we", 32'(we), 0);
        chk("in_rst_stall", 32'(stall), 0);
        chk("in_rst_hold", 32'(md_hold), 0);
        apply(0, ir(1, 0, 20, 0), idleMw, 0, 0, 0, 0, 0, 0);
        chk("after_rst_pend", 32'(pend_count), 0);
        chk("after_rst_stall", 32'(stall), 0);
        chk("after_rst_we", 32'(we), 0);
        apply(0, ir(1, 0, 5, 0), idleMw, 0, 0, 0, 0, 0, 0);
        chk("rst_issue_ignored", 32'(stall), 0);
        chk("rst_no_stale_we", 32'(we), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register address width (2^REG_AW registers).
REQ-003 SHALL have parameter LINK_REG, default 31, meaning the jal destination register.
REQ-004 SHALL have parameter PEND_DEPTH, default 2, meaning the deferred multdiv result FIFO depth (≥1).
REQ-005 SHALL have port clock, input, 1, the single rising-edge clock.
REQ-006 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-007 SHALL have port fd_ir, input, 32, the F/D instruction.
REQ-008 SHALL have port mw_ir, input, 32, the M/W instruction.
REQ-009 SHALL have port mw_data, input, DATA_W, the M/W writeback value.
REQ-010 SHALL have port md_issue, input, 1, pulsed when a mult/div enters the unit.
REQ-011 SHALL have port md_issue_dest, input, REG_AW, the destination of the issued mult/div.
REQ-012 SHALL have port md_ready, input, 1, meaning a mult/div result is valid.
REQ-013 SHALL have port md_dest, input, REG_AW, the destination of the ready result.
REQ-014 SHALL have port md_result, input, DATA_W, the ready result value.
REQ-015 SHALL have outputs read_a and read_b, REG_AW each, the register file read ports.
REQ-016 SHALL have outputs write_d (REG_AW), write_data (DATA_W) and we (1), the register file write port.
REQ-017 SHALL have output stall, 1, meaning freeze F/D due to a pending-result hazard.
REQ-018 SHALL have output md_hold, 1, meaning the multdiv unit must hold its result.
REQ-019 SHALL have output pend_count, clog2(PEND_DEPTH+1) bits, the FIFO occupancy.

Function
REQ-020 SHALL decode opcode = ir[31:27], rd = ir[26:22], rs = ir[21:17], rt = ir[16:12].
REQ-021 SHALL, for fd opcode in {2,4,6}, drive read_a=rd and read_b=rs.
REQ-022 SHALL, for fd opcode in {7,8}, drive read_a=rs and read_b=rd.
REQ-023 SHALL, for all other fd opcodes, drive read_a=rs and read_b=rt.
REQ-024 SHALL treat mw opcodes {0,3,5,8} as an M/W write ("mw_wr"); opcode 3 targets LINK_REG and all others target rd.
REQ-025 SHALL give M/W writes priority on the write port: we=1, write_d/write_data taken from M/W.
REQ-026 SHALL, when mw_wr=0 and the FIFO is non-empty, write the FIFO head and pop it in the same cycle.
REQ-027 SHALL, when mw_wr=0, the FIFO is empty and md_ready=1, write md_result directly (zero latency) and not enqueue it.
REQ-028 SHALL otherwise enqueue md_ready results whenever md_hold=0; an enqueued result is writable no earlier than the next cycle.
REQ-029 SHALL compute md_hold = (FIFO full) and not (pop this cycle); while md_hold=1, the result is not consumed and the unit must present it again.
REQ-030 SHALL keep register 0 unwritable: suppress we for write_d=0, discard md_dest=0 results (consumed, not queued), and never set scoreboard bit 0.
REQ-031 SHALL maintain a 2^REG_AW-bit scoreboard with the following rules:
- md_issue sets bit md_issue_dest at the clock edge;
- the bit is cleared when its result is written to the register file;
- a set and a clear of the same bit in the same cycle leaves the bit set.
REQ-032 SHALL assert stall combinationally when the scoreboard bit is set for read_a, read_b, or the fd destination of opcodes {0,3,5,8}.
REQ-033 SHALL keep FIFO pointers wrapping modulo PEND_DEPTH, with pend_count exact through a simultaneous push and pop.
REQ-034 SHALL, when an M/W write targets a register with a pending scoreboard bit, perform the write and leave the bit set.

Reset
REQ-035 SHALL, on reset=1 at a clock edge, clear the scoreboard and FIFO (pend_count=0) and ignore md_issue and md_ready that cycle.
REQ-036 SHALL, in the reset cycle, drive we=0, stall=0 and md_hold=0 regardless of inputs, including a reset that arrives while the FIFO holds results.

Verification
REQ-037 SHALL verify: mw_ir opcode 3, mw_data=0x40 -> we=1, write_d=31, write_data=0x40.
REQ-038 SHALL verify: md_issue dest 7, then fd_ir add with rs=7 -> stall=1 until the cycle after r7 is written, then stall=0.
REQ-039 SHALL verify: md_ready dest 9 in the same cycle as an M/W ALU write -> the M/W write wins, pend_count=1; next idle cycle we=1, write_d=9, pend_count=0.
REQ-040 SHALL verify, with PEND_DEPTH=2: three consecutive md_ready during continuous M/W writes -> pend_count=2 and md_hold=1 on the third; the held result is written after the FIFO drains, in order.
REQ-041 SHALL verify: md_ready with md_dest=0 on an idle port -> we=0, pend_count unchanged.
REQ-042 SHALL verify: reset with pend_count=2 and scoreboard bits set -> next cycle pend_count=0, stall=0, no stale writes.
